// File: rtl/fifo_pulse_buffer_if.sv
// Push/pop request and status bundle for fifo_pulse_buffer.
// slave = FIFO side, master = requester/display side.
interface fifo_pulse_buffer_if #(
  parameter int B = 8,
  parameter int W = 3
);
  logic         wr_req;
  logic         rd_req;
  logic [B-1:0] w_data;
  logic         err_clr;
  logic [B-1:0] r_data;
  logic         rd_valid;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [W:0]   count;
  logic         overflow;
  logic         underflow;
  logic [1:0]   state;

  modport slave (
    input  wr_req, rd_req, w_data, err_clr,
    output r_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow, state
  );

  modport master (
    output wr_req, rd_req, w_data, err_clr,
    input  r_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow, state
  );
endinterface

// File: rtl/fifo_pulse_buffer.sv
// Synchronous FIFO (2**W x B) driven by debounced push/pop levels, with edge-to-strobe
// conversion, occupancy flags, sticky error flags and an EMPTY/NORMAL/FULL state code.
module fifo_pulse_buffer #(
  parameter int B         = 8,
  parameter int W         = 3,
  parameter int EDGE_MODE = 1,
  parameter int AF_LVL    = 6,
  parameter int AE_LVL    = 1
) (
  input logic              clk,
  input logic              clr,
  fifo_pulse_buffer_if.slave bus
);
  localparam int         DEPTH   = 2 ** W;
  localparam logic [W:0] DEPTH_C = (W + 1)'(DEPTH);
  localparam logic [W:0] AF_C    = (W + 1)'(AF_LVL);
  localparam logic [W:0] AE_C    = (W + 1)'(AE_LVL);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'b00,
    ST_NORMAL = 2'b01,
    ST_FULL   = 2'b11
  } state_e;

  logic [B-1:0] mem [DEPTH];
  logic [W-1:0] wr_ptr_q, rd_ptr_q;
  logic [W:0]   count_q, count_d;
  logic [B-1:0] r_data_q;
  logic         rd_valid_q;
  logic         wr_q, rd_q;
  logic         overflow_q, overflow_d;
  logic         underflow_q, underflow_d;
  state_e       state_q;

  logic full_w, empty_w, push, pop, pop_ok, push_ok;

  // Flags come only from the registered count, never from the request inputs.
  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);

  always_comb begin
    push        = (EDGE_MODE != 0) ? (bus.wr_req & ~wr_q) : bus.wr_req;
    pop         = (EDGE_MODE != 0) ? (bus.rd_req & ~rd_q) : bus.rd_req;
    pop_ok      = pop & ~empty_w;
    push_ok     = push & (~full_w | pop_ok);
    count_d     = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
    overflow_d  = (overflow_q & ~bus.err_clr) | (push & full_w & ~pop_ok);
    underflow_d = (underflow_q & ~bus.err_clr) | (pop & empty_w);
  end

  // Storage is deliberately not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= bus.w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      r_data_q    <= '0;
      rd_valid_q  <= 1'b0;
      wr_q        <= 1'b1;
      rd_q        <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      state_q     <= ST_EMPTY;
    end else begin
      wr_q        <= bus.wr_req;
      rd_q        <= bus.rd_req;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_valid_q  <= pop_ok;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        r_data_q <= mem[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case (state_q)
        ST_EMPTY: begin
          if (push_ok) state_q <= ST_NORMAL;
        end
        ST_NORMAL: begin
          if (count_d == '0) begin
            state_q <= ST_EMPTY;
          end else if (count_d == DEPTH_C) begin
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (pop_ok && !push_ok) state_q <= ST_NORMAL;
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign bus.r_data       = r_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
  assign bus.state        = state_q;
endmodule

// File: tb/tb_fifo_pulse_buffer.sv
// Bench for fifo_pulse_buffer: edge-mode instance against a queue model with random
// operations, plus a level-mode instance for held-request behaviour.
module tb_fifo_pulse_buffer;
  localparam int B = 8;
  localparam int W = 3;
  localparam int DEPTH = 8;

  logic clk;
  logic clr;
  int   total = 0;
  int   bad   = 0;

  logic [B-1:0] exp_q[$];
  logic [B-1:0] exp1_q[$];
  logic [B-1:0] model_q[$];
  bit           m_ovf, m_udf;

  fifo_pulse_buffer_if #(.B(B), .W(W)) e_if ();
  fifo_pulse_buffer_if #(.B(B), .W(W)) l_if ();

  fifo_pulse_buffer #(.B(B), .W(W), .EDGE_MODE(1), .AF_LVL(6), .AE_LVL(1)) dut_edge (
    .clk(clk), .clr(clr), .bus(e_if)
  );
  fifo_pulse_buffer #(.B(B), .W(W), .EDGE_MODE(0), .AF_LVL(6), .AE_LVL(1)) dut_lvl (
    .clk(clk), .clr(clr), .bus(l_if)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitors: pop the expected value whenever the DUT presents rd_valid
  always @(negedge clk) begin
    if (clr && e_if.rd_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL edge_rd_valid: got unexpected pulse, r_data=%0h at %0t", e_if.r_data, $time);
      end else begin
        logic [B-1:0] e;
        e = exp_q.pop_front();
        if (e_if.r_data !== e) begin
          bad++;
          $display("FAIL edge_r_data: got=%0h expected=%0h at %0t", e_if.r_data, e, $time);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (clr && l_if.rd_valid) begin
      total++;
      if (exp1_q.size() == 0) begin
        bad++;
        $display("FAIL lvl_rd_valid: got unexpected pulse, r_data=%0h at %0t", l_if.r_data, $time);
      end else begin
        logic [B-1:0] e;
        e = exp1_q.pop_front();
        if (l_if.r_data !== e) begin
          bad++;
          $display("FAIL lvl_r_data: got=%0h expected=%0h at %0t", l_if.r_data, e, $time);
        end
      end
    end
  end

  // reference model: a plain queue with the acceptance rules applied to pre-edge occupancy
  task automatic model_step(input bit push, input bit pop, input bit ec, input logic [B-1:0] d);
    bit was_empty, was_full, pop_ok, push_ok;
    was_empty = (model_q.size() == 0);
    was_full  = (model_q.size() == DEPTH);
    pop_ok    = pop && !was_empty;
    push_ok   = push && (!was_full || pop_ok);
    m_ovf     = (m_ovf && !ec) || (push && was_full && !pop_ok);
    m_udf     = (m_udf && !ec) || (pop && was_empty);
    if (pop_ok) exp_q.push_back(model_q.pop_front());
    if (push_ok) model_q.push_back(d);
  endtask

  task automatic check_edge(input string tag);
    int n;
    int st;
    n  = model_q.size();
    st = (n == 0) ? 0 : ((n == DEPTH) ? 3 : 1);
    chk({tag, "_count"}, int'(e_if.count), n);
    chk({tag, "_full"}, int'(e_if.full), int'(n == DEPTH));
    chk({tag, "_empty"}, int'(e_if.empty), int'(n == 0));
    chk({tag, "_afull"}, int'(e_if.almost_full), int'(n >= 6));
    chk({tag, "_aempty"}, int'(e_if.almost_empty), int'(n <= 1));
    chk({tag, "_ovf"}, int'(e_if.overflow), int'(m_ovf));
    chk({tag, "_udf"}, int'(e_if.underflow), int'(m_udf));
    chk({tag, "_state"}, int'(e_if.state), st);
  endtask

  // driver: one press = request high for one clk, then released for one clk
  task automatic press(input string tag, input bit w, input bit r, input bit ec,
                       input logic [B-1:0] d);
    e_if.wr_req  = w;
    e_if.rd_req  = r;
    e_if.err_clr = ec;
    e_if.w_data  = d;
    model_step(w, r, ec, d);
    @(negedge clk);
    check_edge(tag);
    e_if.wr_req  = 1'b0;
    e_if.rd_req  = 1'b0;
    e_if.err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic model_reset();
    model_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  initial begin
    e_if.wr_req = 1'b0; e_if.rd_req = 1'b0; e_if.err_clr = 1'b0; e_if.w_data = '0;
    l_if.wr_req = 1'b0; l_if.rd_req = 1'b0; l_if.err_clr = 1'b0; l_if.w_data = '0;
    model_reset();

    // reset with a push request held across reset release
    clr = 1'b0;
    @(negedge clk);
    e_if.wr_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_edge("reset");
    chk("reset_r_data", int'(e_if.r_data), 0);
    chk("reset_rd_valid", int'(e_if.rd_valid), 0);
    e_if.wr_req = 1'b0;
    @(negedge clk);

    // fill, then overflow
    for (int i = 0; i < DEPTH; i++) press("fill", 1'b1, 1'b0, 1'b0, 8'h10 + 8'(i));
    press("ovf", 1'b1, 1'b0, 1'b0, 8'hEE);

    // drain in order, wrap, underflow
    for (int i = 0; i < DEPTH; i++) press("drain", 1'b0, 1'b1, 1'b0, 8'h00);
    press("wrap_push", 1'b1, 1'b0, 1'b0, 8'hA5);
    press("wrap_pop", 1'b0, 1'b1, 1'b0, 8'h00);
    press("udf", 1'b0, 1'b1, 1'b0, 8'h00);
    press("errclr", 1'b0, 1'b0, 1'b1, 8'h00);

    // simultaneous at full and at empty
    for (int i = 0; i < DEPTH; i++) press("fill2", 1'b1, 1'b0, 1'b0, 8'h40 + 8'(i));
    press("both_full", 1'b1, 1'b1, 1'b0, 8'h99);
    for (int i = 0; i < DEPTH; i++) press("drain2", 1'b0, 1'b1, 1'b0, 8'h00);
    press("both_empty", 1'b1, 1'b1, 1'b0, 8'h77);
    press("err_and_new", 1'b0, 1'b1, 1'b1, 8'h00);
    press("err_and_udf", 1'b0, 1'b1, 1'b1, 8'h00);

    // random operations
    for (int i = 0; i < 120; i++) begin
      bit w, r, ec;
      w  = ($urandom_range(0, 99) < 55);
      r  = ($urandom_range(0, 99) < 45);
      ec = ($urandom_range(0, 9) == 0);
      press("rand", w, r, ec, 8'($urandom_range(0, 255)));
    end

    // mid-operation reset at count 5
    while (model_q.size() > 5) press("trim", 1'b0, 1'b1, 1'b0, 8'h00);
    while (model_q.size() < 5) press("grow", 1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
    press("mk_ovf", 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    clr = 1'b0;
    model_reset();
    @(negedge clk);
    clr = 1'b1;
    check_edge("midreset");
    chk("midreset_r_data", int'(e_if.r_data), 0);
    chk("midreset_rd_valid", int'(e_if.rd_valid), 0);
    @(negedge clk);
    press("post_reset_push", 1'b1, 1'b0, 1'b0, 8'h5A);
    press("post_reset_pop", 1'b0, 1'b1, 1'b0, 8'h00);

    // level mode: held wr_req gives one push per clock
    l_if.wr_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      l_if.w_data = 8'h30 + 8'(i);
      exp1_q.push_back(8'h30 + 8'(i));
      @(negedge clk);
    end
    l_if.wr_req = 1'b0;
    chk("lvl_count3", int'(l_if.count), 3);
    chk("lvl_state3", int'(l_if.state), 1);
    l_if.rd_req = 1'b1;
    for (int i = 0; i < 4; i++) @(negedge clk);
    l_if.rd_req = 1'b0;
    chk("lvl_count0", int'(l_if.count), 0);
    chk("lvl_empty", int'(l_if.empty), 1);
    chk("lvl_udf", int'(l_if.underflow), 1);
    l_if.err_clr = 1'b1;
    @(negedge clk);
    l_if.err_clr = 1'b0;
    chk("lvl_udf_clr", int'(l_if.underflow), 0);
    chk("lvl_ovf_clr", int'(l_if.overflow), 0);

    repeat (3) @(negedge clk);
    chk("edge_exp_left", exp_q.size(), 0);
    chk("lvl_exp_left", exp1_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
